// File: rtl/frame_update_scheduler_pkg.sv
`default_nettype none
// frame_update_scheduler_pkg: FSM state encodings and game-logic step indices. rev 1.0
package frame_update_scheduler_pkg;

  localparam int NSTEPS = 4;

  localparam logic [1:0] STEP_INPUT   = 2'd0;
  localparam logic [1:0] STEP_PADDLE  = 2'd1;
  localparam logic [1:0] STEP_BALL    = 2'd2;
  localparam logic [1:0] STEP_COLLIDE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RUN     = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  function automatic logic [NSTEPS-1:0] step_onehot(input logic [1:0] k);
    logic [NSTEPS-1:0] v;
    v = '0;
    v[k] = 1'b1;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/frame_update_scheduler_block_mem_mux.sv
`default_nettype none
// block_mem_mux: hands the block-RAM port to the renderer (read-only) or the logic steps. rev 1.0
module block_mem_mux #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 4
) (
  input  logic              owner,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [ADDR_W-1:0] lg_addr,
  input  logic              lg_we,
  input  logic [DATA_W-1:0] lg_wdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata
);

  always_comb begin
    if (owner) begin
      mem_addr  = lg_addr;
      mem_we    = lg_we;
      mem_wdata = lg_wdata;
    end else begin
      mem_addr  = rd_addr;
      mem_we    = 1'b0;
      mem_wdata = '0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/frame_update_scheduler.sv
`default_nettype none
// frame_update_scheduler: runs the per-frame logic steps during vertical blank and owns the block-RAM port. rev 1.0
module frame_update_scheduler
  import frame_update_scheduler_pkg::*;
#(
  parameter int ADDR_W  = 6,
  parameter int DATA_W  = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              frame_start,
  input  logic              visible,
  input  logic              pause,
  input  logic [NSTEPS-1:0] step_done,
  output logic [NSTEPS-1:0] step_start,
  output logic              busy,
  output logic              mem_owner,
  output logic              overrun,
  output logic              conflict,
  output logic [NSTEPS-1:0] timeout_flags,
  output logic [15:0]       frame_count,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [ADDR_W-1:0] lg_addr,
  input  logic              lg_we,
  input  logic [DATA_W-1:0] lg_wdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  state_t           state;
  logic [1:0]       step;
  logic [CNT_W-1:0] cnt;
  logic             paused;

  logic step_done_seen;
  logic hit_timeout;
  logic last_step;

  // step_start is only high in a step's first cycle, so it doubles as the "ignore done" marker
  always_comb begin
    step_done_seen = (step_start == '0) && step_done[step];
    hit_timeout    = (cnt == TIMEOUT_C);
    last_step      = paused || (step == STEP_COLLIDE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= ST_IDLE;
      step          <= STEP_INPUT;
      cnt           <= '0;
      paused        <= 1'b0;
      step_start    <= '0;
      busy          <= 1'b0;
      mem_owner     <= 1'b0;
      overrun       <= 1'b0;
      conflict      <= 1'b0;
      timeout_flags <= '0;
      frame_count   <= '0;
    end else begin
      step_start <= '0;
      overrun    <= frame_start && (state != ST_IDLE);
      conflict   <= visible && mem_owner;
      case (state)
        ST_IDLE: begin
          if (frame_start) begin
            state     <= ST_GRANT;
            busy      <= 1'b1;
            mem_owner <= 1'b1;
          end
        end
        ST_GRANT: begin
          paused     <= pause;
          step       <= STEP_INPUT;
          cnt        <= '0;
          step_start <= step_onehot(STEP_INPUT);
          state      <= ST_RUN;
        end
        ST_RUN: begin
          if (step_done_seen || hit_timeout) begin
            if (!step_done_seen) begin
              timeout_flags[step] <= 1'b1;
            end
            cnt <= '0;
            if (last_step) begin
              state <= ST_RELEASE;
            end else begin
              step       <= step + 2'd1;
              step_start <= step_onehot(step + 2'd1);
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_RELEASE: begin
          state       <= ST_IDLE;
          busy        <= 1'b0;
          mem_owner   <= 1'b0;
          frame_count <= frame_count + 16'd1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  block_mem_mux #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_block_mem_mux (
    .owner     (mem_owner),
    .rd_addr   (rd_addr),
    .lg_addr   (lg_addr),
    .lg_we     (lg_we),
    .lg_wdata  (lg_wdata),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata)
  );

endmodule
`default_nettype wire

// File: tb/tb_frame_update_scheduler.sv
`default_nettype none
// tb_frame_update_scheduler: directed frames; pulse outputs are matched cycle-exactly against a queue of expected events. rev 1.0
module tb_frame_update_scheduler;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       frame_start = 1'b0;
  logic       visible = 1'b0;
  logic       pause = 1'b0;
  logic [3:0] step_done = 4'b0;
  logic [3:0] step_start;
  logic       busy, mem_owner, overrun, conflict;
  logic [3:0] timeout_flags;
  logic [15:0] frame_count;
  logic [5:0] rd_addr = 6'h00;
  logic [5:0] lg_addr = 6'h00;
  logic       lg_we = 1'b0;
  logic [3:0] lg_wdata = 4'h0;
  logic [5:0] mem_addr;
  logic       mem_we;
  logic [3:0] mem_wdata;

  frame_update_scheduler #(.ADDR_W(6), .DATA_W(4), .TIMEOUT(8)) dut (
    .clock(clock), .reset(reset), .frame_start(frame_start), .visible(visible),
    .pause(pause), .step_done(step_done), .step_start(step_start), .busy(busy),
    .mem_owner(mem_owner), .overrun(overrun), .conflict(conflict),
    .timeout_flags(timeout_flags), .frame_count(frame_count), .rd_addr(rd_addr),
    .lg_addr(lg_addr), .lg_we(lg_we), .lg_wdata(lg_wdata), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wdata(mem_wdata)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [3:0] start;
    logic       ov;
    logic       cf;
  } ev_t;
  ev_t expq[$];

  int n_vec = 0;
  int n_bad = 0;

  // Auto-responder: returns step_done one cycle after each start, except for hung steps
  logic       auto_en = 1'b1;
  logic [3:0] hang = 4'b0;
  logic [3:0] manual_done = 4'b0;
  logic [3:0] prev_start = 4'b0;
  initial forever begin
    @(posedge clock); #1;
    step_done  = auto_en ? (prev_start & ~hang) : manual_done;
    prev_start = step_start;
  end

  always @(negedge clock) begin
    if (step_start != 4'b0 || overrun || conflict) begin
      ev_t e;
      n_vec++;
      if (expq.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_event cyc=%0d: got start=%b ov=%b cf=%b, required no event",
                 cyc, step_start, overrun, conflict);
      end else begin
        e = expq.pop_front();
        if (e.cyc != cyc || e.start != step_start || e.ov != overrun || e.cf != conflict) begin
          n_bad++;
          $display("FAIL event: got cyc=%0d start=%b ov=%b cf=%b, required cyc=%0d start=%b ov=%b cf=%b",
                   cyc, step_start, overrun, conflict, e.cyc, e.start, e.ov, e.cf);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic fire(output int t);
    t = cyc;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic push(input int c, input logic [3:0] s, input logic ov, input logic cf);
    ev_t e;
    e.cyc = c; e.start = s; e.ov = ov; e.cf = cf;
    expq.push_back(e);
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_start"}, 32'(step_start), 32'h0);
    chk({nm, "_busy"}, 32'(busy), 32'h0);
    chk({nm, "_owner"}, 32'(mem_owner), 32'h0);
    chk({nm, "_flags"}, 32'(timeout_flags), 32'h0);
    chk({nm, "_count"}, 32'(frame_count), 32'h0);
    chk({nm, "_ov_cf"}, {30'd0, overrun, conflict}, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    repeat (3) tick();
    chk_reset_vals("reset");
    reset = 1'b0;
    repeat (2) tick();

    // 1: full frame, every step done one cycle after its start
    t = cyc;
    push(t + 2, 4'b0001, 0, 0); push(t + 4, 4'b0010, 0, 0);
    push(t + 6, 4'b0100, 0, 0); push(t + 8, 4'b1000, 0, 0);
    fire(t);
    chk("t1_busy_grant", 32'(busy), 32'h1);
    chk("t1_owner_grant", 32'(mem_owner), 32'h1);
    wait_until(t + 10);
    chk("t1_busy_release", 32'(busy), 32'h1);
    wait_until(t + 11);
    chk("t1_busy_idle", 32'(busy), 32'h0);
    chk("t1_owner_idle", 32'(mem_owner), 32'h0);
    chk("t1_count", 32'(frame_count), 32'h1);
    repeat (3) tick();

    // 2: paused frame runs only the input poll
    t = cyc;
    push(t + 2, 4'b0001, 0, 0);
    pause = 1'b1;
    fire(t);
    wait_until(t + 4);
    chk("t2_busy_release", 32'(busy), 32'h1);
    wait_until(t + 5);
    chk("t2_busy_idle", 32'(busy), 32'h0);
    chk("t2_count", 32'(frame_count), 32'h2);
    pause = 1'b0;
    repeat (3) tick();

    // 3: step 2 hangs and is ended by the timeout
    hang = 4'b0100;
    t = cyc;
    push(t + 2, 4'b0001, 0, 0); push(t + 4, 4'b0010, 0, 0);
    push(t + 6, 4'b0100, 0, 0); push(t + 15, 4'b1000, 0, 0);
    fire(t);
    wait_until(t + 17);
    chk("t3_busy_release", 32'(busy), 32'h1);
    wait_until(t + 18);
    hang = 4'b0;
    chk("t3_busy_idle", 32'(busy), 32'h0);
    chk("t3_flags", 32'(timeout_flags), 32'h4);
    chk("t3_count", 32'(frame_count), 32'h3);
    repeat (3) tick();

    // 4: frame_start during an update is flagged and dropped
    t = cyc;
    push(t + 2, 4'b0001, 0, 0); push(t + 4, 4'b0010, 0, 0);
    push(t + 6, 4'b0100, 1, 0); push(t + 8, 4'b1000, 0, 0);
    fire(t);
    wait_until(t + 5);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    wait_until(t + 14);
    chk("t4_busy_idle", 32'(busy), 32'h0);
    chk("t4_count", 32'(frame_count), 32'h4);
    chk("t4_flags_sticky", 32'(timeout_flags), 32'h4);

    // 5: memory port ownership and visible-while-owned conflicts
    rd_addr = 6'h15; lg_addr = 6'h2A; lg_we = 1'b1; lg_wdata = 4'hC;
    visible = 1'b1;
    tick(); tick();
    chk("t5_idle_addr", 32'(mem_addr), 32'h15);
    chk("t5_idle_we", 32'(mem_we), 32'h0);
    chk("t5_idle_wdata", 32'(mem_wdata), 32'h0);
    visible = 1'b0;
    t = cyc;
    push(t + 2, 4'b0001, 0, 0); push(t + 4, 4'b0010, 0, 1);
    push(t + 5, 4'b0000, 0, 1); push(t + 6, 4'b0100, 0, 0);
    push(t + 8, 4'b1000, 0, 0);
    fire(t);
    wait_until(t + 3);
    chk("t5_run_addr", 32'(mem_addr), 32'h2A);
    chk("t5_run_we", 32'(mem_we), 32'h1);
    chk("t5_run_wdata", 32'(mem_wdata), 32'hC);
    visible = 1'b1;
    wait_until(t + 5);
    visible = 1'b0;
    wait_until(t + 11);
    chk("t5_count", 32'(frame_count), 32'h5);
    chk("t5_idle_addr2", 32'(mem_addr), 32'h15);
    lg_we = 1'b0;
    repeat (3) tick();

    // 6: reset in the middle of step 1 aborts everything
    t = cyc;
    push(t + 2, 4'b0001, 0, 0); push(t + 4, 4'b0010, 0, 0);
    fire(t);
    wait_until(t + 4);
    reset = 1'b1;
    tick();
    chk_reset_vals("t6");
    reset = 1'b0;
    auto_en = 1'b0;
    manual_done = 4'hF;
    repeat (3) tick();
    manual_done = 4'h0;
    tick();
    chk("t6_busy_after", 32'(busy), 32'h0);
    chk("t6_count_after", 32'(frame_count), 32'h0);

    repeat (4) tick();
    while (expq.size() != 0) begin
      ev_t e;
      e = expq.pop_front();
      n_vec++;
      n_bad++;
      $display("FAIL missing_event: got nothing, required cyc=%0d start=%b ov=%b cf=%b",
               e.cyc, e.start, e.ov, e.cf);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
